// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder (171/133 octal) with automatic zero-tail flush per frame.
// Optional rate-2/3 puncturing with an out_mask port is enabled by defining CONV_ENC_PUNCT_EN.
module conv_enc_k7 #(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = 7'o171,
  parameter logic [K-1:0] G1 = 7'o133
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
`ifdef CONV_ENC_PUNCT_EN
  ,
  output logic [1:0] out_mask
`endif
);

  localparam int            CW       = $clog2(K - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 2);

  localparam logic [0:0] ST_DATA  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    state;
  logic [K-2:0]  sr;
  logic [CW-1:0] flush_cnt;

  logic          load;
  logic          take_in;
  logic          emit;
  logic          b;
  logic [K-1:0]  v;
  logic [1:0]    code;

`ifdef CONV_ENC_PUNCT_EN
  logic          odd;
`endif

  // sr[0] holds the newest past bit; the tap vector places it right below the current bit.
  always_comb begin
    load     = !out_valid || out_ready;
    in_ready = !rst && (state == ST_DATA) && load;
    take_in  = in_valid && in_ready;
    emit     = take_in || ((state == ST_FLUSH) && load);
    b        = (state == ST_DATA) && in_bit;
    v        = '0;
    v[K-1]   = b;
    for (int i = 0; i < K - 1; i++) begin
      v[K-2-i] = sr[i];
    end
    code     = {^(G1 & v), ^(G0 & v)};
  end

  assign busy = (state == ST_FLUSH) || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_DATA;
      sr        <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_pair  <= 2'b00;
      out_last  <= 1'b0;
`ifdef CONV_ENC_PUNCT_EN
      out_mask  <= 2'b00;
      odd       <= 1'b0;
`endif
    end else begin
      if (load) begin
        out_valid <= emit;
      end
      if (emit) begin
        sr       <= {sr[K-3:0], b};
        out_last <= (state == ST_FLUSH) && (flush_cnt == LAST_CNT);
`ifdef CONV_ENC_PUNCT_EN
        out_mask <= odd ? 2'b01 : 2'b11;
        out_pair <= odd ? {1'b0, code[0]} : code;
        // Symbol index parity restarts with every frame, so clear it on the final tail symbol.
        odd      <= ((state == ST_FLUSH) && (flush_cnt == LAST_CNT)) ? 1'b0 : !odd;
`else
        out_pair <= code;
`endif
        if (state == ST_DATA) begin
          if (in_last) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end else if (flush_cnt == LAST_CNT) begin
          state     <= ST_DATA;
          flush_cnt <= '0;
        end else begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/conv_enc_k7.md
Name: conv_enc_k7

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder with generators 171/133 (octal). It is the transmit-side counterpart of the 64-state Viterbi decoder.
- Takes one information bit per handshake and emits one 2-bit code symbol per handshake. The symbol bit order is identical to the decoder's received-pair input.
- Appends K-1 zero tail bits after each frame, so every frame terminates the trellis in state 0.

Parameters:
- K, 7, constraint length; the shift register holds K-1 = 6 bits.
- G0, 7'o171, generator for out_pair[0]; bit K-1 taps the current input bit.
- G1, 7'o133, generator for out_pair[1]; bit K-1 taps the current input bit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  information bit valid.
- in_ready  out  1  encoder can accept a bit this cycle.
- in_bit  in  1  information bit.
- in_last  in  1  marks the final information bit of the frame.
- out_valid  out  1  code symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_pair  out  2  code symbol; [0] is the G0 parity, [1] is the G1 parity.
- out_last  out  1  marks the final tail symbol of the frame.
- busy  out  1  high in FLUSH or while out_valid=1.

Behaviour:
- Reset (async, active-high) sets: state=DATA, sr=0, flush_cnt=0, out_valid=0, out_pair=0, out_last=0, in_ready=0 while rst is high.
- Encoding:
  - Let v = {b, sr[K-2:0]}, where b is the current bit and sr[0] is the most recent past bit.
  - out_pair[j] = XOR-reduce(Gj & v), where bit K-1 of Gj multiplies b.
  - After each symbol, sr <= {sr[K-3:0], b}.
- Output register: single-entry, fully registered.
  - A symbol is loaded when (!out_valid || out_ready).
  - Latency is 1 cycle from input acceptance to out_valid.
  - Full throughput: one symbol per cycle when out_ready is held high.
- in_ready = (state==DATA) && (!out_valid || out_ready). This is combinational from out_ready.
- out_valid stays high until out_ready. out_pair and out_last are stable while out_valid=1 && !out_ready.
- State machine:
  - DATA: each accepted bit produces a symbol with out_last=0. If the accepted bit has in_last=1, go to FLUSH with flush_cnt=0.
  - FLUSH: in_ready=0, b=0. Whenever the output register can load, emit one tail symbol and increment flush_cnt.
  - The symbol emitted with flush_cnt==K-2 has out_last=1. Return to DATA; sr is then 0 by construction.
- Boundaries:
  - A frame of N bits yields exactly N+6 symbols.
  - A frame of a single bit with in_last=1 is legal.
  - in_valid without in_last continues the frame indefinitely; there is no length limit.
  - Backpressure during FLUSH stalls flush_cnt; no symbol is lost or duplicated.
  - Reset mid-frame or mid-flush aborts the frame immediately. No tail is emitted.
  - in_bit and in_last are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: CONV_ENC_PUNCT_EN.
- Defined:
  - Adds output port out_mask[1:0].
  - Applies a rate-2/3 puncture pattern: symbols at even index within the frame get out_mask=2'b11; odd index gets out_mask=2'b01 (G1 bit punctured).
  - Punctured out_pair bits are driven 0. The index counts all symbols including tail and resets to 0 at each frame start.
  - out_mask resets to 2'b00.
- Undefined: no out_mask port. Every symbol carries both parity bits unchanged.

Test Plan:
- Single-bit impulse: in_bit=1, in_last=1, out_ready=1.
  - Expect 7 symbols out_pair = 11,01,11,11,00,10,11 on consecutive cycles.
  - out_last=1 only on the 7th symbol; busy drops the cycle after.
- All-zero 16-bit frame: expect 22 symbols, all 2'b00. in_ready stays 0 for 6 cycles of FLUSH.
- Backpressure: impulse frame with out_ready toggled 1,0,0,1,...
  - Expect the same 7-symbol sequence, each held stable while stalled.
  - in_ready=0 whenever out_valid && !out_ready.
- Back-to-back frames: impulse frame immediately followed by another impulse frame.
  - Second frame's symbols identical to the first (sr cleared).
  - First in_ready of frame 2 occurs in the cycle the frame-1 out_last symbol is accepted.
- Reset mid-flush: assert rst after the 3rd tail symbol.
  - Outputs go to reset values asynchronously.
  - A subsequent impulse frame produces the exact impulse sequence.
- CONV_ENC_PUNCT_EN defined, impulse frame: out_mask = 11,01,11,01,11,01,11 and out_pair = 11,01,11,01,00,00,11.
